// File: rtl/instr_pkg.sv
// instr_pkg: shared definitions for the instruction loader.
//   - packet field positions inside the 24-bit config address
//   - command opcodes carried in the data byte of a command packet
//   - word packer state encoding and lane helpers
package instr_pkg;

  // address field layout
  localparam int CMD_BIT = 23;
  localparam int ID_MSB  = 22;
  localparam int ID_LSB  = 16;

  // command opcodes
  localparam logic [7:0] OPC_START = 8'h01;
  localparam logic [7:0] OPC_CLEAR = 8'h02;

  // byte lanes per instruction word
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;
  localparam int WORD_W    = NUM_LANES * LANE_W;

  // ASSEMBLE <=> at least one lane of a word is pending
  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_ASSEMBLE = 1'b1
  } ld_state_e;

  // one-hot lane select
  function automatic logic [NUM_LANES-1:0] lane_bit(input logic [1:0] lane);
    logic [NUM_LANES-1:0] b;
    b       = '0;
    b[lane] = 1'b1;
    return b;
  endfunction

endpackage

// File: rtl/word_packer.sv
// word_packer: assembles little-endian byte writes into 32-bit words.
//   clk, reset    : clock, synchronous active-high reset
//   byte_vld      : accepted, in-range data byte this cycle
//   flush         : drop any partial word (CLEAR command)
//   lane, waddr   : byte lane and word address of the byte
//   din           : data byte
//   done          : word completes this cycle (combinational)
//   done_addr     : word address of the completed word
//   done_data     : completed word including the current byte
//   err_hit       : address-change or premature lane-3 error this cycle
module word_packer
  import instr_pkg::*;
#(
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              byte_vld,
  input  logic              flush,
  input  logic [1:0]        lane,
  input  logic [MEM_AW-1:0] waddr,
  input  logic [7:0]        din,
  output logic              done,
  output logic [MEM_AW-1:0] done_addr,
  output logic [WORD_W-1:0] done_data,
  output logic              err_hit
);

  ld_state_e                state_q, state_d;
  logic [NUM_LANES-1:0]     mask_q, mask_d;
  logic [WORD_W-1:0]        data_q, data_d;
  logic [MEM_AW-1:0]        pend_q, pend_d;

  logic                     addr_chg;
  logic [NUM_LANES-1:0]     base_mask;
  logic [NUM_LANES-1:0]     new_mask;

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    data_d    = data_q;
    pend_d    = pend_q;
    done      = 1'b0;
    err_hit   = 1'b0;
    addr_chg  = 1'b0;
    base_mask = mask_q;
    new_mask  = mask_q;

    if (flush) begin
      mask_d  = '0;
      state_d = ST_IDLE;
    end else if (byte_vld) begin
      // a byte for a different word abandons the partial one and
      // restarts assembly from an empty mask with this byte
      addr_chg  = (state_q == ST_ASSEMBLE) && (waddr != pend_q);
      base_mask = addr_chg ? '0 : mask_q;
      new_mask  = base_mask | lane_bit(lane);
      data_d[lane*LANE_W +: LANE_W] = din;
      pend_d    = waddr;
      if (lane == 2'd3) begin
        // lane 3 always closes the word, complete or not
        mask_d  = '0;
        state_d = ST_IDLE;
        if (new_mask == '1) done = 1'b1;
        else                err_hit = 1'b1;
      end else begin
        mask_d  = new_mask;
        state_d = ST_ASSEMBLE;
      end
      if (addr_chg) err_hit = 1'b1;
    end
  end

  assign done_addr = waddr;
  assign done_data = data_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      data_q  <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// instr_loader: consumes the instruction-config byte stream, keeps packets
// for this operator, builds 32-bit instruction words and writes them into
// the operator's local instruction memory; decodes start/clear commands.
//   clk, reset     : clock, synchronous active-high reset
//   instr_wr_en_in : byte strobe, no backpressure
//   addr           : [23] command, [22:16] target id, [15:0] byte address
//   din            : data byte or command opcode
//   mem_we/addr/wdata : registered instruction memory write port
//   start, clear   : one-cycle command pulses
//   word_cnt       : words written since reset/clear, saturating
//   err            : sticky error, cleared by reset or CLEAR
module instr_loader
  import instr_pkg::*;
#(
  parameter logic [6:0] OP_ID  = 7'd0,
  parameter int         MEM_AW = 10,
  parameter int         CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_wr_en_in,
  input  logic [23:0]       addr,
  input  logic [7:0]        din,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              start,
  output logic              clear,
  output logic [CNT_W-1:0]  word_cnt,
  output logic              err
);

  // packet classification
  logic hit, is_cmd, oor;
  logic data_vld, cmd_start, cmd_clear, cmd_bad;

  assign hit    = instr_wr_en_in && (addr[ID_MSB:ID_LSB] == OP_ID);
  assign is_cmd = addr[CMD_BIT];
  // byte address beyond the instruction memory
  assign oor    = (addr[15:0] >> (MEM_AW + 2)) != 16'd0;

  assign data_vld  = hit && !is_cmd && !oor;
  assign cmd_start = hit &&  is_cmd && (din == OPC_START);
  assign cmd_clear = hit &&  is_cmd && (din == OPC_CLEAR);
  assign cmd_bad   = hit &&  is_cmd && !cmd_start && !cmd_clear;

  logic              pk_done, pk_err;
  logic [MEM_AW-1:0] pk_addr;
  logic [31:0]       pk_data;

  word_packer #(.MEM_AW(MEM_AW)) u_packer (
    .clk       (clk),
    .reset     (reset),
    .byte_vld  (data_vld),
    .flush     (cmd_clear),
    .lane      (addr[1:0]),
    .waddr     (addr[MEM_AW+1:2]),
    .din       (din),
    .done      (pk_done),
    .done_addr (pk_addr),
    .done_data (pk_data),
    .err_hit   (pk_err)
  );

  logic              mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              start_q, start_d;
  logic              clear_q, clear_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic              err_q, err_d;

  always_comb begin
    mem_we_d    = pk_done;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    start_d     = cmd_start;
    clear_d     = cmd_clear;
    word_cnt_d  = word_cnt_q;
    err_d       = err_q;

    // address/data hold their last written value between writes
    if (pk_done) begin
      mem_addr_d  = pk_addr;
      mem_wdata_d = pk_data;
    end

    if (cmd_clear) begin
      word_cnt_d = '0;
      err_d      = 1'b0;
    end else begin
      if (pk_done && (word_cnt_q != '1)) word_cnt_d = word_cnt_q + CNT_W'(1);
      if (pk_err || cmd_bad || (hit && !is_cmd && oor)) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      start_q     <= 1'b0;
      clear_q     <= 1'b0;
      word_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      start_q     <= start_d;
      clear_q     <= clear_d;
      word_cnt_q  <= word_cnt_d;
      err_q       <= err_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign start     = start_q;
  assign clear     = clear_q;
  assign word_cnt  = word_cnt_q;
  assign err       = err_q;

endmodule
